// File: rtl/mat_alu_pipe_if.sv
// mat_alu_pipe_if: operand/result handshake bundle for mat_alu_pipe.
interface mat_alu_pipe_if #(
    parameter int W_IN  = 8,
    parameter int W_OUT = 32,
    parameter int N     = 4
);
    logic                                  in_valid;
    logic                                  in_ready;
    logic [1:0]                            op;
    logic [N-1:0][N-1:0][W_IN-1:0]         matrix_a;
    logic [N-1:0][N-1:0][W_IN-1:0]         matrix_b;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [N-1:0][N-1:0][W_OUT-1:0]        result;
    logic                                  busy;
    modport master (
        output in_valid, op, matrix_a, matrix_b, out_ready,
        input  in_ready, out_valid, result, busy
    );
    modport slave (
        input  in_valid, op, matrix_a, matrix_b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mat_alu_pipe.sv
// mat_alu_pipe: pipelined N x N signed matmul / add / sub / Hadamard unit.
// Optional MAT_ALU_SATURATE_EN clamps narrowed results and adds sticky sat_flag.
module mat_alu_pipe #(
    parameter int W_IN  = 8,
    parameter int W_OUT = 32,
    parameter int N     = 4
) (
    input logic clk,
    input logic rst,
    input logic cen,
    mat_alu_pipe_if.slave bus
`ifdef MAT_ALU_SATURATE_EN
    ,
    output logic sat_flag
`endif
);
    localparam int DEPTH = $clog2(N);
    localparam int WI    = 2 * W_IN + DEPTH;
    localparam int H     = N / 2;

    typedef logic signed [WI-1:0] acc_t;

    acc_t                           tr [DEPTH+1][N][N][N];
    acc_t                           d0 [N][N][N];
    logic [DEPTH:0]                 vld;
    logic [1:0]                     ops [DEPTH+1];
    logic [W_OUT-1:0]               nar [N][N];
    logic [N-1:0][N-1:0][W_OUT-1:0] res_q;
    logic                           out_q;
    logic                           stall;
    logic                           adv;
    logic                           accept;

    function automatic acc_t sx(input logic [W_IN-1:0] v);
        return acc_t'($signed(v));
    endfunction

    function automatic acc_t ew(input logic [1:0] o, input logic [W_IN-1:0] a, input logic [W_IN-1:0] b);
        return o == 2'b01 ? sx(a) + sx(b) : o == 2'b10 ? sx(a) - sx(b) : sx(a) * sx(b);
    endfunction

    assign stall         = out_q && !bus.out_ready;
    assign adv           = cen && !stall;
    assign bus.in_ready  = cen && !stall && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_q;
    assign bus.result    = res_q;
    assign bus.busy      = |vld || out_q;

    // Element-wise ops use slot 0 only so every opcode rides the same tree depth.
    always_comb begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < N; k++)
                    d0[i][j][k] = bus.op == 2'b00 ? sx(bus.matrix_a[i][k]) * sx(bus.matrix_b[k][j])
                                : k != 0 ? '0 : ew(bus.op, bus.matrix_a[i][j], bus.matrix_b[i][j]);
    end

`ifdef MAT_ALU_SATURATE_EN
    logic [N*N-1:0] clip;
    logic           out_sat;
`endif

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            acc_t f;
            assign f = tr[DEPTH][i][j][0];
            if (W_OUT >= WI) begin : g_ext
                assign nar[i][j] = W_OUT'(f);
`ifdef MAT_ALU_SATURATE_EN
                assign clip[i*N+j] = 1'b0;
`endif
            end else begin : g_cut
`ifdef MAT_ALU_SATURATE_EN
                localparam acc_t HI = acc_t'({(W_OUT-1){1'b1}});
                localparam acc_t LO = -HI - acc_t'(1);
                assign clip[i*N+j] = f > HI || f < LO;
                assign nar[i][j]   = f > HI ? HI[W_OUT-1:0] : f < LO ? LO[W_OUT-1:0] : f[W_OUT-1:0];
`else
                assign nar[i][j] = f[W_OUT-1:0];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld   <= '0;
            out_q <= 1'b0;
            res_q <= '0;
            for (int s = 0; s <= DEPTH; s++) begin
                ops[s] <= 2'b00;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        for (int k = 0; k < N; k++)
                            tr[s][i][j][k] <= '0;
            end
`ifdef MAT_ALU_SATURATE_EN
            out_sat  <= 1'b0;
            sat_flag <= 1'b0;
`endif
        end else if (adv) begin
            vld   <= {vld[DEPTH-1:0], accept};
            out_q <= vld[DEPTH];
            if (accept) begin
                tr[0]  <= d0;
                ops[0] <= bus.op;
            end
            // Upper slots of tree stages are never written and stay at their reset zero.
            for (int s = 1; s <= DEPTH; s++) begin
                ops[s] <= ops[s-1];
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        for (int k = 0; k < H; k++)
                            tr[s][i][j][k] <= k < (N >> s) ? tr[s-1][i][j][2*k] + tr[s-1][i][j][2*k+1] : '0;
            end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    res_q[i][j] <= nar[i][j];
`ifdef MAT_ALU_SATURATE_EN
            out_sat  <= |clip;
            sat_flag <= sat_flag || (out_q && bus.out_ready && out_sat);
`endif
        end
    end
endmodule

// File: tb/tb_mat_alu_pipe.sv
// tb_mat_alu_pipe: directed table plus stall/cen/reset sequences, N=2, and a W_OUT=8 narrowing instance.
module tb_mat_alu_pipe;
    localparam int N = 2;

    typedef struct {
        logic [1:0] op;
        int a[4];
        int b[4];
        int c[4];
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t tv[6];

    mat_alu_pipe_if #(.W_IN(8), .W_OUT(32), .N(N)) bus ();
    mat_alu_pipe_if #(.W_IN(8), .W_OUT(8),  .N(N)) bus8 ();

    mat_alu_pipe #(.W_IN(8), .W_OUT(32), .N(N)) dut (
        .clk(clk), .rst(rst), .cen(cen), .bus(bus)
`ifdef MAT_ALU_SATURATE_EN
        , .sat_flag()
`endif
    );

`ifdef MAT_ALU_SATURATE_EN
    logic sat8;
`endif
    mat_alu_pipe #(.W_IN(8), .W_OUT(8), .N(N)) dut8 (
        .clk(clk), .rst(rst), .cen(cen), .bus(bus8)
`ifdef MAT_ALU_SATURATE_EN
        , .sat_flag(sat8)
`endif
    );

    assign bus8.in_valid  = bus.in_valid;
    assign bus8.op        = bus.op;
    assign bus8.matrix_a  = bus.matrix_a;
    assign bus8.matrix_b  = bus.matrix_b;
    assign bus8.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] o, input int a[4], input int b[4]);
        bus.op = o;
        for (int e = 0; e < 4; e++) begin
            bus.matrix_a[e/2][e%2] = 8'(a[e]);
            bus.matrix_b[e/2][e%2] = 8'(b[e]);
        end
    endtask

    task automatic chk_res(input string name, input int c[4]);
        for (int e = 0; e < 4; e++)
            chk(name, longint'($signed(bus.result[e/2][e%2])), longint'(c[e]));
    endtask

    function automatic int ga(input int seed, input int k, input int e);
        return ((seed + k * 37 + e * 53) % 256) - 128;
    endfunction

    function automatic int gb(input int seed, input int k, input int e);
        return ((seed * 3 + k * 29 + e * 71) % 256) - 128;
    endfunction

    function automatic int mm(input int seed, input int k, input int e);
        int i = e / 2;
        int j = e % 2;
        return ga(seed, k, i*2) * gb(seed, k, j) + ga(seed, k, i*2+1) * gb(seed, k, 2+j);
    endfunction

    // Streams n matmuls; out_ready low in [slo,shi], cen low in [clo,chi]; first>=0 checks delivery cycle.
    task automatic stream(input int n, input int seed, input int slo, input int shi,
                          input int clo, input int chi, input int first);
        int sent = 0;
        int recv = 0;
        bit hv = 0;
        bit acc;
        int a[4], b[4], c[4];
        logic [N-1:0][N-1:0][31:0] held = '0;
        for (int cy = 0; cy < 60 && recv < n; cy++) begin
            @(negedge clk);
            bus.out_ready = !(cy >= slo && cy <= shi);
            cen = !(cy >= clo && cy <= chi);
            bus.in_valid = sent < n;
            for (int e = 0; e < 4; e++) begin
                a[e] = ga(seed, sent, e);
                b[e] = gb(seed, sent, e);
            end
            drive(2'b00, a, b);
            #1;
            if (!cen || (bus.out_valid && !bus.out_ready)) chk("hold_in_ready", bus.in_ready, 0);
            if (hv) chk("hold_result", bus.result == held, 1);
            hv = !cen || (bus.out_valid && !bus.out_ready);
            held = bus.result;
            if (cen && bus.out_valid && bus.out_ready) begin
                for (int e = 0; e < 4; e++) c[e] = mm(seed, recv, e);
                chk_res("stream_result", c);
                if (first >= 0) chk("deliver_cycle", cy, first + recv);
                recv++;
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc) sent++;
        end
        chk("stream_count", recv, n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        cen = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int c8[4];
        int ones[4];
        tv[0] = '{2'd0, '{1, 2, 3, 4},         '{5, 6, 7, 8},         '{19, 22, 43, 50}};
        tv[1] = '{2'd1, '{-128, 127, 5, -3},   '{-1, 1, 2, 2},        '{-129, 128, 7, -1}};
        tv[2] = '{2'd2, '{-128, 127, 5, -3},   '{-1, 1, 2, 2},        '{-127, 126, 3, -5}};
        tv[3] = '{2'd3, '{-128, 127, 5, -3},   '{-1, 1, 2, 2},        '{128, 127, 10, -6}};
        tv[4] = '{2'd0, '{-128, -128, -128, -128}, '{-128, -128, -128, -128}, '{32768, 32768, 32768, 32768}};
        tv[5] = '{2'd0, '{1, -2, 3, 0},        '{-4, 5, 6, 7},        '{-16, -9, -12, 15}};
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = 2'b00;
        bus.matrix_a = '0;
        bus.matrix_b = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result == '0, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            drive(tv[v].op, tv[v].a, tv[v].b);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            chk("lat_busy", bus.busy, 1);
            @(posedge clk);
            #1;
            chk("lat_early", bus.out_valid, 0);
            @(posedge clk);
            #1;
            chk("lat_valid", bus.out_valid, 1);
            chk_res("vec_result", tv[v].c);
            @(posedge clk);
            #1;
            chk("lat_pulse", bus.out_valid, 0);
        end

        @(negedge clk);
        drive(tv[1].op, tv[1].a, tv[1].b);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(tv[2].op, tv[2].a, tv[2].b);
        @(posedge clk);
        #1;
        drive(tv[3].op, tv[3].a, tv[3].b);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            chk("b2b_valid", bus.out_valid, 1);
            chk_res("b2b_result", tv[v].c);
            @(posedge clk);
            #1;
        end
        chk("b2b_end_valid", bus.out_valid, 0);
        chk("b2b_end_busy", bus.busy, 0);

        stream(6, 11, 3, 5, -1, -1, -1);
        stream(4, 57, -1, -1, 2, 3, 5);

        @(negedge clk);
        drive(tv[0].op, tv[0].a, tv[0].b);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(tv[5].op, tv[5].a, tv[5].b);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_ready", bus.in_ready, 0);
        chk("async_rst_result", bus.result == '0, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int cy = 0; cy < 6; cy++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        chk("no_stale", seen, 0);
`ifdef MAT_ALU_SATURATE_EN
        chk("sat_clear", sat8, 0);
`endif

        for (int e = 0; e < 4; e++) ones[e] = 127;
        @(negedge clk);
        drive(2'b00, ones, ones);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("narrow_valid", bus8.out_valid, 1);
`ifdef MAT_ALU_SATURATE_EN
        for (int e = 0; e < 4; e++) c8[e] = 127;
        chk("sat_before_xfer", sat8, 0);
`else
        for (int e = 0; e < 4; e++) c8[e] = 2;
`endif
        for (int e = 0; e < 4; e++)
            chk("narrow_result", longint'($signed(bus8.result[e/2][e%2])), longint'(c8[e]));
        @(posedge clk);
        #1;
`ifdef MAT_ALU_SATURATE_EN
        chk("sat_flag", sat8, 1);
`endif
        chk("narrow_done", bus8.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mat_alu_pipe.md
Name: mat_alu_pipe

Overview:
- Parametrised successor to the team's fixed-function matrix multiply/add unit.
- Computes an N x N signed matrix operation per transaction, selected by a 2-bit opcode:
  - matrix multiply
  - element-wise add
  - element-wise subtract
  - element-wise (Hadamard) multiply
- Fully pipelined, one transaction per cycle, valid/ready handshake with backpressure on both sides. The latency is identical for every opcode.
- Sits between the SIMD operand buffers and the writeback stage.

Parameters:
- W_IN, 8, signed element width of both input matrices.
- W_OUT, 32, signed element width of the result.
- N, 4, matrix dimension (N x N). Must be a power of two, >= 2.
- Derived: DEPTH = $clog2(N); WI = 2*W_IN + DEPTH (internal full-precision width); LAT = DEPTH + 1.

Ports:
- clk  in  1  Clock, rising edge.
- rst  in  1  Asynchronous, active-high reset.
- cen  in  1  Clock enable; low freezes all pipeline state.
- in_valid  in  1  Operands and op are valid.
- in_ready  out  1  Block accepts a transaction this cycle.
- op  in  2  00 = matmul, 01 = add, 10 = sub (A-B), 11 = Hadamard multiply.
- matrix_a  in  N*N*W_IN  Packed [N][N][W_IN], signed, row-major.
- matrix_b  in  N*N*W_IN  Same packing as matrix_a.
- out_valid  out  1  result is valid.
- out_ready  in  1  Downstream accepts result.
- result  out  N*N*W_OUT  Packed [N][N][W_OUT], signed.
- busy  out  1  Any pipeline stage holds a valid transaction.

Behaviour:
- Reset (async assert, sync release):
  - All stage valid bits = 0, all data/op registers = 0.
  - Outputs: out_valid = 0, result = 0, busy = 0, in_ready = 0 while rst is high.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = cen && !stall && !rst.
  - A new transaction is not accepted during a stall: the whole pipeline holds (global stall, no skid buffer).
  - result and out_valid are stable while stalled.
- cen = 0: no register updates, in_ready = 0, outputs held; cen has no effect on reset.
- Pipeline: stage 0 register is loaded on accept, then DEPTH adder-tree stages follow.
  - Each stage carries a valid bit and a 2-bit op.
  - Bubbles propagate with valid = 0.
  - Accept at edge t -> out_valid at edge t+LAT when there is no stall or cen-low cycle in between.
- Arithmetic: all in signed WI bits, with inputs sign-extended.
  - matmul: stage 0 registers products a[i][k]*b[k][j] for all k. Tree stages sum pairs; the final stage gives C[i][j] = sum over k.
  - add / sub / Hadamard: stage 0 computes a[i][j] op b[i][j] into tree slot 0 and zeroes the other slots. The tree adds zeros, so latency is identical to matmul.
  - Output narrowing WI -> W_OUT: sign-extend if W_OUT >= WI; otherwise two's-complement truncation (wrap), unless SATURATE_EN is defined.
- Ordering: results emerge strictly in acceptance order. Opcodes may change every cycle with no bubbles required.
- Simultaneous accept and output transfer in the same cycle is legal and sustains full throughput (1 per cycle).
- Reset mid-operation: all in-flight transactions are discarded; none emerge after reset release.
- in_valid while in_ready = 0: operands are ignored. The source must hold them (AXI-style); the block does not latch them.

Optional Feature:
- Macro: MAT_ALU_SATURATE_EN.
- Defined and W_OUT < WI: each result element clamps to [-2^(W_OUT-1), 2^(W_OUT-1)-1]. Sticky output port sat_flag (1 bit) is added: it is set when any element of any transaction clamps at output transfer, and cleared only by rst.
- Not defined: wrap truncation and no sat_flag port.
- W_OUT >= WI: the macro has no functional effect; sat_flag stays 0.

Test Plan:
- N=2, op=00, A=[[1,2],[3,4]], B=[[5,6],[7,8]], out_ready=1 -> after LAT=2 cycles result=[[19,22],[43,50]], out_valid pulses 1 cycle.
- N=2, back-to-back ops 01, 10, 11 on A=[[-128,127],[5,-3]], B=[[-1,1],[2,2]], one per cycle -> consecutive results [[-129,128],[7,-1]], [[-127,126],[3,-5]], [[128,127],[10,-6]] in order, no gaps.
- Stream of 6 matmuls with out_ready low for cycles 3-5 -> in_ready=0 during the stall, result held stable, all 6 results delivered in order with none lost or duplicated.
- cen low for 2 cycles mid-stream -> no state change; delivery is delayed by exactly 2 cycles.
- rst pulse with 2 transactions in flight -> out_valid=0, busy=0 immediately (async); no stale results after release.
- MAT_ALU_SATURATE_EN, N=2, W_OUT=8, op=00, A=B=[[127,127],[127,127]] -> all elements = 127, sat_flag=1. Without the macro, all elements = 2 (32258 mod 256), no sat_flag port.
